// File: rtl/combo_lock_pkg.sv
// Shared types and key constants for the combination lock controller.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    SET_NEW  = 3'd4,
    LOCKOUT  = 3'd5
  } state_e;

  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_STAR = 4'hF;
  localparam logic [3:0] KEY_A    = 4'hA;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Millisecond timer: free-running tick prescaler plus a loadable 16-bit ms down-counter.
module lock_timer #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expired
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   ms_q, ms_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
    ms_d  = ms_q;
    // A load always wins, so a tick coinciding with the load is not counted.
    if (load) begin
      ms_d = load_val;
    end else if (tick && (ms_q != '0)) begin
      ms_d = ms_q - 16'd1;
    end
    expired = tick && (ms_q == 16'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry, code check, unlock/lockout timing and code change.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN     = 4,
  parameter logic [23:0] DEFAULT_CODE = 24'h001234,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned UNLOCK_MS    = 5000,
  parameter int unsigned LOCKOUT_MS   = 30000,
  parameter int unsigned ENTRY_TO_MS  = 10000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  input  logic                  key_valid,
  output logic                  unlocked,
  output logic                  lockout,
  output logic [2:0]            state_o,
  output logic [2:0]            digit_cnt,
  output logic [4*CODE_LEN-1:0] entry_digits,
  output logic [2:0]            attempts_left,
  output logic                  err_pulse,
  output logic                  code_set_pulse
);

  localparam int unsigned BW = 4 * CODE_LEN;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d, code_q, code_d;
  logic [2:0]    cnt_q, cnt_d, fail_q, fail_d, fail_inc;
  logic          err_q, err_d, set_q, set_d, unl_q, unl_d, lko_q, lko_d;
  logic          t_load, t_expired, full;
  logic [15:0]   t_val;

  lock_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (MAX10_CLK1_50),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    code_d   = code_q;
    err_d    = 1'b0;
    set_d    = 1'b0;
    t_load   = 1'b0;
    t_val    = 16'(ENTRY_TO_MS);
    full     = (cnt_q == 3'(CODE_LEN));
    fail_inc = fail_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            buf_d   = BW'(key_code);
            cnt_d   = 3'd1;
            t_load  = 1'b1;
            state_d = ENTRY;
          end else if (key_code == KEY_HASH) begin
            err_d = 1'b1;
          end
        end
      end

      // Both entry states share digit collection; they differ only on '#'.
      ENTRY, SET_NEW: begin
        if (t_expired) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (key_valid) begin
          if (is_digit(key_code)) begin
            if (!full) begin
              buf_d  = (buf_q << 4) | BW'(key_code);
              cnt_d  = cnt_q + 3'd1;
              t_load = 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (key_code == KEY_HASH) begin
            if (state_q == ENTRY) begin
              if (full) begin
                state_d = CHECK;
              end else begin
                err_d   = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
              end
            end else if (full) begin
              code_d  = buf_q;
              set_d   = 1'b1;
              buf_d   = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = '0;
          t_load  = 1'b1;
          t_val   = 16'(UNLOCK_MS);
          state_d = UNLOCKED;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == 3'(MAX_TRIES)) begin
            t_load  = 1'b1;
            t_val   = 16'(LOCKOUT_MS);
            state_d = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      UNLOCKED: begin
        if (t_expired) begin
          state_d = IDLE;
        end else if (key_valid) begin
          if (key_code == KEY_STAR) begin
            state_d = IDLE;
          end else if (key_code == KEY_A) begin
            t_load  = 1'b1;
            state_d = SET_NEW;
          end
        end
      end

      LOCKOUT: begin
        if (t_expired) begin
          fail_d  = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    unl_d = (state_d == UNLOCKED) || (state_d == SET_NEW);
    lko_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE[BW-1:0];
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      set_q   <= 1'b0;
      unl_q   <= 1'b0;
      lko_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      set_q   <= set_d;
      unl_q   <= unl_d;
      lko_q   <= lko_d;
    end
  end

  always_comb begin
    attempts_left = (fail_q >= 3'(MAX_TRIES)) ? 3'd0 : 3'(MAX_TRIES) - fail_q;
  end

  assign unlocked       = unl_q;
  assign lockout        = lko_q;
  assign state_o        = state_q;
  assign digit_cnt      = cnt_q;
  assign entry_digits   = buf_q;
  assign err_pulse      = err_q;
  assign code_set_pulse = set_q;

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequencing controller for the combination lock. It consumes decoded keypad events (4-bit key code plus a one-cycle valid strobe from the keypad scanner) and collects digit entries. It compares each entry against a stored code and drives the unlock, lockout and code-change flow with millisecond timers. Its outputs feed the HEX/LEDR display logic and the lock actuator pin.

Parameters:
CODE_LEN, 4, number of digits in a code (1..6)
DEFAULT_CODE, 24'h001234, reset code; the low 4*CODE_LEN bits are used, BCD, newest digit in bits [3:0]
TICK_DIV, 50000, clock cycles per 1 ms tick (50 MHz)
MAX_TRIES, 3, wrong attempts before lockout (1..7)
UNLOCK_MS, 5000, auto-relock delay
LOCKOUT_MS, 30000, lockout duration
ENTRY_TO_MS, 10000, inactivity timeout while digits are pending

Ports:
MAX10_CLK1_50  in  1  system clock
rst  in  1  asynchronous, active-high reset
key_code  in  4  0-9 digits; A-D = 4'hA-4'hD; 4'hE = '#' (enter); 4'hF = '*' (clear)
key_valid  in  1  one-cycle strobe; key_code is qualified by it
unlocked  out  1  lock open
lockout  out  1  lockout active
state_o  out  3  encoded FSM state for the LEDs
digit_cnt  out  3  digits currently buffered
entry_digits  out  4*CODE_LEN  entry buffer, newest digit in [3:0]
attempts_left  out  3  MAX_TRIES minus failed attempts
err_pulse  out  1  one cycle on rejected entry
code_set_pulse  out  1  one cycle when a new code is stored

Behaviour:
- Reset (async, immediate): state=IDLE; code_reg=DEFAULT_CODE; buffer=0; digit_cnt=0; fail_cnt=0; timer and prescaler cleared; all pulses and flags 0; attempts_left=MAX_TRIES.
- Prescaler: free-running counter 0..TICK_DIV-1; tick is asserted for one cycle at TICK_DIV-1. Timer load=N means expiry on the Nth tick after load. A load in the same cycle as a tick does not count that tick.
- key_valid is evaluated only in IDLE, ENTRY, UNLOCKED and SET_NEW. It is dropped in all other states.
- States:
  - IDLE (locked, buffer empty). Digit -> shift into buffer, digit_cnt=1, load ENTRY_TO_MS, go to ENTRY. '#' -> err_pulse, stay. A-D and '*' are ignored.
  - ENTRY. Digit with digit_cnt<CODE_LEN -> shift left 4, insert at [3:0], digit_cnt++, reload timeout. Digit with digit_cnt==CODE_LEN -> ignored, no timeout reload. '*' -> clear buffer, go to IDLE. '#' with digit_cnt==CODE_LEN -> CHECK. '#' with a short entry -> err_pulse, clear, go to IDLE; not counted as an attempt. Timeout expiry -> clear, go to IDLE.
  - CHECK (exactly 1 cycle). buffer==code_reg -> fail_cnt=0, load UNLOCK_MS, go to UNLOCKED. Mismatch -> err_pulse and fail_cnt++. If the new fail_cnt==MAX_TRIES, load LOCKOUT_MS and go to LOCKOUT; otherwise go to IDLE. The buffer is cleared on exit either way.
  - UNLOCKED. unlocked=1. Expiry -> IDLE. '*' -> immediate relock to IDLE. 'A' -> load ENTRY_TO_MS, go to SET_NEW. Other keys are ignored.
  - SET_NEW. unlocked=1. Digits and the timeout behave as in ENTRY. '#' with a full buffer -> code_reg=buffer, code_set_pulse, clear, go to IDLE. '#' with a short buffer -> err_pulse, stay, buffer kept. '*' or timeout -> abort, code unchanged, go to IDLE.
  - LOCKOUT. lockout=1, all keys are dropped. Expiry -> fail_cnt=0, go to IDLE.
- Simultaneous timer expiry and key_valid: expiry wins and the key is dropped.
- unlocked and lockout are registered from state. They are never both 1.
- attempts_left is combinational from fail_cnt and saturates at 0.

Decomposition:
- Package combo_lock_pkg holds:
  - state enum (IDLE, ENTRY, CHECK, UNLOCKED, SET_NEW, LOCKOUT) with explicit 3-bit encodings used for state_o;
  - key constants KEY_HASH=4'hE, KEY_STAR=4'hF, KEY_A=4'hA;
  - function is_digit.
- One sub-module, lock_timer: prescaler plus a 16-bit ms down-counter. Ports: load, load_val, expired pulse.

Test Plan (TICK_DIV=4, UNLOCK_MS=5, LOCKOUT_MS=8, ENTRY_TO_MS=6, MAX_TRIES=3):
1. Keys 1,2,3,4,'#' -> CHECK for 1 cycle, then unlocked=1. After 5 ticks (≤20 cycles) unlocked=0 and state=IDLE.
2. Keys 9,9,9,9,'#' three times -> err_pulse 3×, attempts_left 2,1,0, lockout=1. Keys during lockout are ignored. After 8 ticks state=IDLE and attempts_left=3.
3. Keys 1,2,'#' -> err_pulse, attempts_left stays 3. Then 1,2,3,4,5 -> entry_digits=16'h1234, digit_cnt=4.
4. Unlock, press 'A', keys 5,6,7,8,'#' -> code_set_pulse, locked. 1,2,3,4,'#' now fails; 5,6,7,8,'#' unlocks.
5. Keys 1,2 then idle 6 ticks -> buffer cleared, IDLE. A key_valid on the expiry cycle is dropped.
6. Assert rst mid-ENTRY and mid-LOCKOUT -> all outputs return to reset values asynchronously and the code reverts to DEFAULT_CODE.
